hpu_id_dec_grp: RTL and testbench

- Parametrised, multi-lane successor of the scalar ID0 decoder: sits between fetch and rename.
- Buffers fetched instructions in a circular instruction queue and forms decode groups of up to DEC_WIDTH instructions per cycle under grouping rules.
- Per-lane decode uses the standard hpu_pkg field functions (get_rs1/rs2/rd) and opcode classes, with the same illegal-opcode rules as the scalar ID0 decoder.
- Drives a registered decode-group output with a valid/ready handshake, and supports pipeline flush.

---
 rtl/hpu_id_dec_grp.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_hpu_id_dec_grp.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpu_id_dec_grp.sv
// Multi-lane decode stage: a circular instruction queue feeding
// grouped per-lane decode into a registered valid/ready output.
package hpu_pkg;
  typedef logic [31:0] inst_t;
  typedef logic [31:0] pc_t;
  typedef logic [4:0]  arc_sr_index_t;

  typedef enum logic [2:0] {
    TO_NONE,
    TO_ALU,
    TO_LSU,
    TO_MDU,
    TO_VMU
  } issue_type_e;

  localparam logic [6:0] OPC_LD       = 7'h03;
  localparam logic [6:0] OPC_MAT      = 7'h0B;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OPI      = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_ST       = 7'h23;
  localparam logic [6:0] OPC_ATOM     = 7'h2F;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_VEC      = 7'h57;
  localparam logic [6:0] OPC_BR       = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    inst_t         inst;
    pc_t           pc;
    issue_type_e   issue_type;
    logic          jbr;
    logic          ld;
    logic          st;
    logic          excp;
    arc_sr_index_t rs1;
    arc_sr_index_t rs2;
    arc_sr_index_t rd;
    logic          rdst_en;
  } dec_lane_t;

  function automatic logic [6:0] get_opcode(inst_t i);
    return i[6:0];
  endfunction

  function automatic arc_sr_index_t get_rs1(inst_t i);
    return i[19:15];
  endfunction

  function automatic arc_sr_index_t get_rs2(inst_t i);
    return i[24:20];
  endfunction

  function automatic arc_sr_index_t get_rd(inst_t i);
    return i[11:7];
  endfunction

  function automatic logic [2:0] get_funct3(inst_t i);
    return i[14:12];
  endfunction

  function automatic logic [6:0] get_funct7(inst_t i);
    return i[31:25];
  endfunction

  function automatic logic is_legal(inst_t i);
    logic [6:0] o;
    o = get_opcode(i);
    return o inside {OPC_LD, OPC_MAT, OPC_MISC_MEM, OPC_OPI,
                     OPC_AUIPC, OPC_ST, OPC_ATOM, OPC_OP,
                     OPC_LUI, OPC_VEC, OPC_BR, OPC_JALR,
                     OPC_JAL, OPC_SYSTEM};
  endfunction

  function automatic logic is_ser(inst_t i);
    logic [6:0] o;
    o = get_opcode(i);
    return (o == OPC_MISC_MEM) || (o == OPC_SYSTEM) || !is_legal(i);
  endfunction

  function automatic logic is_mdu(inst_t i);
    return (get_opcode(i) == OPC_OP) && (get_funct7(i) == 7'h01);
  endfunction

  function automatic logic is_jbr(inst_t i);
    logic [6:0] o;
    o = get_opcode(i);
    return (o == OPC_BR) || (o == OPC_JAL) || (o == OPC_JALR);
  endfunction

  function automatic dec_lane_t decode_inst(inst_t i, pc_t pc);
    dec_lane_t  d;
    logic [6:0] o;
    logic [2:0] f3;
    d      = '0;
    o      = get_opcode(i);
    f3     = get_funct3(i);
    d.inst = i;
    d.pc   = pc;
    d.rs1  = get_rs1(i);
    d.rs2  = get_rs2(i);
    d.rd   = get_rd(i);
    unique case (1'b1)
      o == OPC_LD: begin
        d.issue_type = TO_LSU;
        d.ld         = 1'b1;
        d.rdst_en    = 1'b1;
      end
      o == OPC_ST: begin
        d.issue_type = TO_LSU;
        d.st         = 1'b1;
      end
      o == OPC_ATOM: begin
        d.issue_type = TO_LSU;
        d.rdst_en    = 1'b1;
      end
      o == OPC_MISC_MEM: begin
        if (f3 == 3'd0) d.issue_type = TO_LSU;
        else if (f3 != 3'd1) d.excp = 1'b1;
      end
      o == OPC_SYSTEM: begin
        // csr space 0xBC0-0xBFF belongs to the vector unit
        if (f3 != 3'd0) begin
          if (i[31:26] == 6'b101111) begin
            d.issue_type = TO_VMU;
          end else begin
            d.issue_type = TO_LSU;
            d.rdst_en    = 1'b1;
          end
        end
      end
      o == OPC_OP: begin
        d.issue_type = is_mdu(i) ? TO_MDU : TO_ALU;
        d.rdst_en    = 1'b1;
      end
      o == OPC_OPI,
      o == OPC_LUI,
      o == OPC_AUIPC: begin
        d.issue_type = TO_ALU;
        d.rdst_en    = 1'b1;
      end
      o == OPC_BR: begin
        d.issue_type = TO_ALU;
        d.jbr        = 1'b1;
      end
      o == OPC_JAL,
      o == OPC_JALR: begin
        d.issue_type = TO_ALU;
        d.jbr        = 1'b1;
        d.rdst_en    = 1'b1;
      end
      o == OPC_VEC,
      o == OPC_MAT: begin
        d.issue_type = TO_VMU;
      end
      default: begin
        d.excp = 1'b1;
      end
    endcase
    return d;
  endfunction
endpackage

module hpu_id_dec_grp
  import hpu_pkg::*;
#(
  parameter int DEC_WIDTH  = 2,
  parameter int IBUF_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [DEC_WIDTH-1:0]               fetch_vld_i,
  input  inst_t [DEC_WIDTH-1:0]              fetch_inst_i,
  input  pc_t [DEC_WIDTH-1:0]                fetch_pc_i,
  output logic                               fetch_rdy_o,
  output logic [DEC_WIDTH-1:0]               dec_vld_o,
  input  logic                               dec_rdy_i,
  output inst_t [DEC_WIDTH-1:0]              dec_inst_o,
  output pc_t [DEC_WIDTH-1:0]                dec_pc_o,
  output issue_type_e [DEC_WIDTH-1:0]        dec_issue_type_o,
  output logic [DEC_WIDTH-1:0]               dec_is_jbr_o,
  output logic [DEC_WIDTH-1:0]               dec_is_ld_o,
  output logic [DEC_WIDTH-1:0]               dec_is_st_o,
  output logic [DEC_WIDTH-1:0]               dec_excp_en_o,
  output arc_sr_index_t [DEC_WIDTH-1:0]      dec_rs1_o,
  output arc_sr_index_t [DEC_WIDTH-1:0]      dec_rs2_o,
  output arc_sr_index_t [DEC_WIDTH-1:0]      dec_rd_o,
  output logic [DEC_WIDTH-1:0]               dec_rdst_en_o
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;

  inst_t q_inst [IBUF_DEPTH];
  pc_t   q_pc   [IBUF_DEPTH];

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] n_enq, n_pop;
  logic          ld;

  logic [DEC_WIDTH-1:0]      vld_q, vld_d;
  dec_lane_t [DEC_WIDTH-1:0] lane_q, lane_d;

  assign fetch_rdy_o = !rst_i &&
    ((IBUF_DEPTH - int'(cnt_q)) >= DEC_WIDTH);
  assign ld = !(|vld_q) || dec_rdy_i;

  always_comb begin : c_enq
    logic run;
    run   = 1'b1;
    n_enq = '0;
    for (int k = 0; k < DEC_WIDTH; k++) begin
      if (!fetch_vld_i[k]) run = 1'b0;
      if (run) n_enq = n_enq + CW'(1);
    end
    if (!fetch_rdy_o || flush_i) n_enq = '0;
  end

  // walk lanes from the head; stop at the first grouping violation
  always_comb begin : c_grp
    logic [PW-1:0] idx;
    logic          open;
    logic          mdu_seen;
    logic          take;
    vld_d    = '0;
    lane_d   = '0;
    n_pop    = '0;
    open     = 1'b1;
    mdu_seen = 1'b0;
    for (int k = 0; k < DEC_WIDTH; k++) begin
      idx  = head_q + PW'(k);
      take = 1'b0;
      if (open && (CW'(k) < cnt_q)) begin
        if (is_ser(q_inst[idx])) begin
          open = 1'b0;
          take = (k == 0);
        end else if (is_mdu(q_inst[idx]) && mdu_seen) begin
          open = 1'b0;
        end else begin
          take     = 1'b1;
          open     = !is_jbr(q_inst[idx]);
          mdu_seen = mdu_seen | is_mdu(q_inst[idx]);
        end
      end
      if (take) begin
        vld_d[k]  = 1'b1;
        lane_d[k] = decode_inst(q_inst[idx], q_pc[idx]);
        n_pop     = n_pop + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DEC_WIDTH; k++) begin
      if (CW'(k) < n_enq) begin
        q_inst[tail_q + PW'(k)] <= fetch_inst_i[k];
        q_pc[tail_q + PW'(k)]   <= fetch_pc_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      lane_q <= '0;
    end else begin
      tail_q <= tail_q + n_enq[PW-1:0];
      cnt_q  <= cnt_q + n_enq - (ld ? n_pop : '0);
      if (ld) begin
        head_q <= head_q + n_pop[PW-1:0];
        vld_q  <= vld_d;
        lane_q <= lane_d;
      end
    end
  end

  assign dec_vld_o = vld_q;

  for (genvar k = 0; k < DEC_WIDTH; k++) begin : g_out
    assign dec_inst_o[k]       = lane_q[k].inst;
    assign dec_pc_o[k]         = lane_q[k].pc;
    assign dec_issue_type_o[k] = lane_q[k].issue_type;
    assign dec_is_jbr_o[k]     = lane_q[k].jbr;
    assign dec_is_ld_o[k]      = lane_q[k].ld;
    assign dec_is_st_o[k]      = lane_q[k].st;
    assign dec_excp_en_o[k]    = lane_q[k].excp;
    assign dec_rs1_o[k]        = lane_q[k].rs1;
    assign dec_rs2_o[k]        = lane_q[k].rs2;
    assign dec_rd_o[k]         = lane_q[k].rd;
    assign dec_rdst_en_o[k]    = lane_q[k].rdst_en;
  end

endmodule

// File: tb/tb_hpu_id_dec_grp.sv
// Bench for hpu_id_dec_grp: directed groups plus random traffic
// against a queue-based reference model.
module tb_hpu_id_dec_grp;
  import hpu_pkg::*;

  localparam int W = 2;
  localparam int D = 8;

  logic                     clk = 1'b0;
  logic                     rst_i;
  logic                     flush_i;
  logic [W-1:0]             fetch_vld_i;
  inst_t [W-1:0]            fetch_inst_i;
  pc_t [W-1:0]              fetch_pc_i;
  logic                     fetch_rdy_o;
  logic [W-1:0]             dec_vld_o;
  logic                     dec_rdy_i;
  inst_t [W-1:0]            dec_inst_o;
  pc_t [W-1:0]              dec_pc_o;
  issue_type_e [W-1:0]      dec_issue_type_o;
  logic [W-1:0]             dec_is_jbr_o;
  logic [W-1:0]             dec_is_ld_o;
  logic [W-1:0]             dec_is_st_o;
  logic [W-1:0]             dec_excp_en_o;
  arc_sr_index_t [W-1:0]    dec_rs1_o;
  arc_sr_index_t [W-1:0]    dec_rs2_o;
  arc_sr_index_t [W-1:0]    dec_rd_o;
  logic [W-1:0]             dec_rdst_en_o;

  hpu_id_dec_grp #(.DEC_WIDTH(W), .IBUF_DEPTH(D)) u_dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .fetch_vld_i      (fetch_vld_i),
    .fetch_inst_i     (fetch_inst_i),
    .fetch_pc_i       (fetch_pc_i),
    .fetch_rdy_o      (fetch_rdy_o),
    .dec_vld_o        (dec_vld_o),
    .dec_rdy_i        (dec_rdy_i),
    .dec_inst_o       (dec_inst_o),
    .dec_pc_o         (dec_pc_o),
    .dec_issue_type_o (dec_issue_type_o),
    .dec_is_jbr_o     (dec_is_jbr_o),
    .dec_is_ld_o      (dec_is_ld_o),
    .dec_is_st_o      (dec_is_st_o),
    .dec_excp_en_o    (dec_excp_en_o),
    .dec_rs1_o        (dec_rs1_o),
    .dec_rs2_o        (dec_rs2_o),
    .dec_rd_o         (dec_rd_o),
    .dec_rdst_en_o    (dec_rdst_en_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] MUL   = 32'h023100B3;
  localparam logic [31:0] BAD   = 32'h0000007F;

  typedef enum {
    K_ILL, K_LD, K_ST, K_ATOM, K_FENCE, K_FENCEI, K_MMBAD,
    K_CSR, K_VCSR, K_ENV, K_OP, K_MDU, K_OPI, K_BR, K_JAL,
    K_JALR, K_LUI, K_AUIPC, K_VEC, K_MAT
  } kls_e;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  ent_t         mq[$];
  logic [W-1:0] e_vld;
  logic [127:0] e_lane [W];
  int n_err = 0;
  int n_chk = 0;
  int n_push = 0;
  int n_acc = 0;
  logic [31:0] pc_ctr = 32'h1000;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic kls_e klass(logic [31:0] i);
    case (i[6:0])
      7'h03: return K_LD;
      7'h23: return K_ST;
      7'h2F: return K_ATOM;
      7'h0F: begin
        if (i[14:12] == 3'd0) return K_FENCE;
        if (i[14:12] == 3'd1) return K_FENCEI;
        return K_MMBAD;
      end
      7'h73: begin
        if (i[14:12] == 3'd0) return K_ENV;
        if (i[31:26] == 6'b101111) return K_VCSR;
        return K_CSR;
      end
      7'h33: return (i[31:25] == 7'd1) ? K_MDU : K_OP;
      7'h13: return K_OPI;
      7'h63: return K_BR;
      7'h6F: return K_JAL;
      7'h67: return K_JALR;
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h57: return K_VEC;
      7'h0B: return K_MAT;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] unit_of(kls_e c);
    if (c inside {K_LD, K_ST, K_ATOM, K_FENCE, K_CSR}) return 3'd2;
    if (c inside {K_OP, K_OPI, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC})
      return 3'd1;
    if (c == K_MDU) return 3'd3;
    if (c inside {K_VEC, K_MAT, K_VCSR}) return 3'd4;
    return 3'd0;
  endfunction

  function automatic bit serial(kls_e c);
    return c inside {K_FENCE, K_FENCEI, K_MMBAD, K_CSR,
                     K_VCSR, K_ENV, K_ILL};
  endfunction

  function automatic logic [127:0] pk(
    logic [31:0] inst, logic [31:0] pc, logic [2:0] it,
    logic jbr, logic ld, logic st, logic ex,
    logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic rdst);
    return {41'd0, inst, pc, it, jbr, ld, st, ex, rs1, rs2, rd, rdst};
  endfunction

  function automatic logic [127:0] ref_lane(ent_t e);
    kls_e c;
    c = klass(e.inst);
    return pk(e.inst, e.pc, unit_of(c),
              c inside {K_BR, K_JAL, K_JALR},
              c == K_LD, c == K_ST, c inside {K_ILL, K_MMBAD},
              e.inst[19:15], e.inst[24:20], e.inst[11:7],
              c inside {K_LD, K_OP, K_OPI, K_MDU, K_JAL, K_JALR,
                        K_LUI, K_AUIPC, K_ATOM, K_CSR});
  endfunction

  task automatic model_update();
    bit can;
    int n;
    bit mdu;
    kls_e c;
    ent_t e;
    if (rst_i || flush_i) begin
      mq.delete();
      e_vld = '0;
      for (int k = 0; k < W; k++) e_lane[k] = '0;
      return;
    end
    can = (D - mq.size()) >= W;
    if (e_vld == '0 || dec_rdy_i) begin
      n   = 0;
      mdu = 0;
      for (int k = 0; k < W; k++) begin
        if (k >= mq.size()) break;
        c = klass(mq[k].inst);
        if (serial(c)) begin
          if (k == 0) n = 1;
          break;
        end
        if (c == K_MDU && mdu) break;
        n = k + 1;
        if (c == K_MDU) mdu = 1;
        if (c inside {K_BR, K_JAL, K_JALR}) break;
      end
      e_vld = '0;
      for (int k = 0; k < W; k++) e_lane[k] = '0;
      for (int k = 0; k < n; k++) begin
        e_vld[k]  = 1'b1;
        e_lane[k] = ref_lane(mq[k]);
      end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
    end
    if (can) begin
      for (int k = 0; k < W; k++) begin
        if (!fetch_vld_i[k]) break;
        e.inst = fetch_inst_i[k];
        e.pc   = fetch_pc_i[k];
        mq.push_back(e);
        n_push++;
      end
    end
  endtask

  task automatic check_all();
    check("vld", dec_vld_o, e_vld);
    check("fetch_rdy", fetch_rdy_o,
          !rst_i && ((D - mq.size()) >= W));
    for (int k = 0; k < W; k++) begin
      check($sformatf("lane%0d", k),
            pk(dec_inst_o[k], dec_pc_o[k], dec_issue_type_o[k],
               dec_is_jbr_o[k], dec_is_ld_o[k], dec_is_st_o[k],
               dec_excp_en_o[k], dec_rs1_o[k], dec_rs2_o[k],
               dec_rd_o[k], dec_rdst_en_o[k]),
            e_lane[k]);
    end
  endtask

  task automatic step();
    if (!rst_i && !flush_i && dec_rdy_i)
      n_acc += $countones(dec_vld_o);
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic fetch(logic [W-1:0] v, logic [31:0] i0, logic [31:0] i1);
    fetch_vld_i     = v;
    fetch_inst_i[0] = i0;
    fetch_inst_i[1] = i1;
    fetch_pc_i[0]   = pc_ctr;
    fetch_pc_i[1]   = pc_ctr + 32'd4;
    pc_ctr          = pc_ctr + 32'd8;
  endtask

  task automatic idle();
    fetch_vld_i = '0;
  endtask

  task automatic do_reset();
    rst_i   = 1'b1;
    flush_i = 1'b0;
    idle();
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rdy_after_rst", fetch_rdy_o, 1'b1);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    i = $urandom;
    case ($urandom_range(0, 15))
      0:  i[6:0] = 7'h03;
      1:  i[6:0] = 7'h23;
      2:  i[6:0] = 7'h2F;
      3: begin
        i[6:0]   = 7'h0F;
        i[14:12] = 3'($urandom_range(0, 3));
      end
      4: begin
        i[6:0] = 7'h73;
        if ($urandom_range(0, 1) == 1) i[31:26] = 6'b101111;
        if ($urandom_range(0, 2) == 0) i[14:12] = 3'd0;
      end
      5, 6: begin
        i[6:0]   = 7'h33;
        i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h01 : 7'h00;
      end
      7:  i[6:0] = 7'h13;
      8:  i[6:0] = 7'h63;
      9:  i[6:0] = 7'h6F;
      10: i[6:0] = 7'h67;
      11: i[6:0] = 7'h37;
      12: i[6:0] = 7'h17;
      13: i[6:0] = 7'h57;
      14: i[6:0] = 7'h0B;
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    dec_rdy_i    = 1'b1;
    fetch_vld_i  = '0;
    fetch_inst_i = '0;
    fetch_pc_i   = '0;
    e_vld        = '0;
    for (int k = 0; k < W; k++) e_lane[k] = '0;
    #2;
    do_reset();

    fetch(2'b11, ADDI, LW);
    step();
    idle();
    step();
    check("t1_vld", dec_vld_o, 2'b11);
    check("t1_it0", dec_issue_type_o[0], TO_ALU);
    check("t1_it1", dec_issue_type_o[1], TO_LSU);
    check("t1_ld", dec_is_ld_o, 2'b10);
    check("t1_rd", {dec_rd_o[1], dec_rd_o[0]}, {5'd2, 5'd1});
    check("t1_rdst", dec_rdst_en_o, 2'b11);
    step();

    fetch(2'b11, BEQ, ADD);
    step();
    idle();
    step();
    check("t2_vld", dec_vld_o, 2'b01);
    check("t2_jbr", dec_is_jbr_o, 2'b01);
    step();
    check("t2_add", dec_inst_o[0], ADD);
    step();

    fetch(2'b11, ADD, ECALL);
    step();
    idle();
    step();
    check("t3_vld_a", dec_vld_o, 2'b01);
    step();
    check("t3_vld_e", dec_vld_o, 2'b01);
    check("t3_ecall", dec_issue_type_o[0], TO_NONE);
    fetch(2'b11, BAD, ADD);
    step();
    idle();
    step();
    check("t3_bad_vld", dec_vld_o, 2'b01);
    check("t3_bad_ex", dec_excp_en_o, 2'b01);
    step();
    step();

    fetch(2'b11, MUL, MUL);
    step();
    idle();
    step();
    check("t5_vld0", dec_vld_o, 2'b01);
    check("t5_mdu0", dec_issue_type_o[0], TO_MDU);
    step();
    check("t5_vld1", dec_vld_o, 2'b01);
    check("t5_mdu1", dec_issue_type_o[0], TO_MDU);
    step();

    do_reset();
    n_push    = 0;
    n_acc     = 0;
    dec_rdy_i = 1'b0;
    for (int g = 0; g < 6; g++) begin
      fetch(2'b11, ADDI | (32'(g) << 7), ADDI | (32'(g + 8) << 7));
      step();
    end
    check("t4_full", fetch_rdy_o, 1'b0);
    idle();
    dec_rdy_i = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("t4_drain", n_acc, n_push);
    check("t4_empty", dec_vld_o, '0);

    do_reset();
    dec_rdy_i = 1'b0;
    fetch(2'b11, ADD, ADDI);
    step();
    fetch(2'b11, ADD, ADDI);
    step();
    fetch(2'b11, ADD, ADDI);
    step();
    fetch(2'b01, ADD, ADDI);
    step();
    check("t6_pre_vld", dec_vld_o, 2'b11);
    flush_i = 1'b1;
    fetch(2'b11, LW, LW);
    step();
    check("t6_fl_vld", dec_vld_o, '0);
    check("t6_fl_rdy", fetch_rdy_o, 1'b1);
    flush_i   = 1'b0;
    dec_rdy_i = 1'b1;
    fetch(2'b11, ADDI, LW);
    step();
    idle();
    step();
    check("t6_post_vld", dec_vld_o, 2'b11);
    fetch(2'b10, ADDI, ADDI);
    step();
    idle();
    step();
    check("t6_skip_vld", dec_vld_o, '0);

    for (int c = 0; c < 3000; c++) begin
      rst_i     = ($urandom_range(0, 299) == 0);
      flush_i   = ($urandom_range(0, 59) == 0);
      dec_rdy_i = ($urandom_range(0, 9) < 7);
      fetch(W'($urandom), rnd_inst(), rnd_inst());
      step();
    end
    rst_i   = 1'b0;
    flush_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
